ama_riscv_retire_tracer: RTL and testbench

AMA_RISCV_RETIRE_TRACER -- requirements
Module: ama_riscv_retire_tracer

---
 rtl/ama_riscv_retire_tracer.sv | 163 ++++++++++++++++
 tb/tb_ama_riscv_retire_tracer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_retire_tracer.sv
// Retire tracer: captures retired-instruction records into a FIFO while tracing
// is active and keeps free-running performance counters for every retire.
module ama_riscv_retire_tracer #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_en,
    input  logic                     cnt_clear,
    input  logic                     in_valid,
    input  logic [31:0]              in_inst,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_dmem_addr,
    input  logic                     in_branch_inst,
    input  logic                     in_branch_taken,
    input  logic                     in_bp_hit,
    input  logic [3:0]               in_dmem_size,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [102:0]             out_data,
    output logic [31:0]              out_seq,
    output logic [31:0]              cnt_inst,
    output logic [31:0]              cnt_branch,
    output logic [31:0]              cnt_taken,
    output logic [31:0]              cnt_bp_miss,
    output logic [31:0]              cnt_load,
    output logic [31:0]              cnt_store,
    output logic [15:0]              cnt_drop,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    // Stored entry: 103-bit record followed by the 32-bit retire index
    localparam int unsigned RW = 103 + 32;
    localparam logic [AW:0] LvlFull = (AW+1)'(DEPTH);
    localparam logic [AW:0] LvlOne  = (AW+1)'(1);
    localparam logic [AW-1:0] PtrOne = AW'(1);

    typedef enum logic [1:0] {StIdle, StActive, StDrain} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [RW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_level;
    logic [31:0]     r_cnt_inst;
    logic [31:0]     r_cnt_branch;
    logic [31:0]     r_cnt_taken;
    logic [31:0]     r_cnt_bp_miss;
    logic [31:0]     r_cnt_load;
    logic [31:0]     r_cnt_store;
    logic [15:0]     r_cnt_drop;
    logic            r_overflow;

    logic            w_push_req;
    logic            w_pop;
    logic            w_full;
    logic            w_push;
    logic            w_drop;
    logic [RW-1:0]   w_head;

    assign w_full     = (r_level == LvlFull);
    assign w_pop      = (r_level != '0) && out_ready;
    assign w_push_req = (r_state == StActive) && in_valid;
    // A full FIFO still takes the new record when the head leaves this cycle
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;
    assign w_head     = r_mem[r_rptr];

    // Capture-mode FSM next-state decode
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:   if (trace_en) w_state_nxt = StActive;
            StActive: if (!trace_en) w_state_nxt = StDrain;
            StDrain: begin
                if (trace_en)             w_state_nxt = StActive;
                else if (r_level == '0)   w_state_nxt = StIdle;
            end
            default:  w_state_nxt = StIdle;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= StIdle;
        else      r_state <= w_state_nxt;
    end

    // FIFO storage; contents are don't-care until pushed, output is masked by level
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_inst, in_pc, in_dmem_addr, in_dmem_size,
                              in_branch_inst, in_branch_taken, in_bp_hit, r_cnt_inst};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PtrOne;
            if (w_pop)  r_rptr <= r_rptr + PtrOne;
            if (w_push && !w_pop)      r_level <= r_level + LvlOne;
            else if (!w_push && w_pop) r_level <= r_level - LvlOne;
        end
    end

    // Performance counters, drop counter and sticky overflow; clear wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt_inst    <= '0;
            r_cnt_branch  <= '0;
            r_cnt_taken   <= '0;
            r_cnt_bp_miss <= '0;
            r_cnt_load    <= '0;
            r_cnt_store   <= '0;
            r_cnt_drop    <= '0;
            r_overflow    <= 1'b0;
        end else if (cnt_clear) begin
            r_cnt_inst    <= '0;
            r_cnt_branch  <= '0;
            r_cnt_taken   <= '0;
            r_cnt_bp_miss <= '0;
            r_cnt_load    <= '0;
            r_cnt_store   <= '0;
            r_cnt_drop    <= '0;
            r_overflow    <= 1'b0;
        end else begin
            if (in_valid) begin
                r_cnt_inst <= r_cnt_inst + 32'd1;
                if (in_branch_inst)                    r_cnt_branch  <= r_cnt_branch + 32'd1;
                if (in_branch_inst && in_branch_taken) r_cnt_taken   <= r_cnt_taken + 32'd1;
                if (in_branch_inst && !in_bp_hit)      r_cnt_bp_miss <= r_cnt_bp_miss + 32'd1;
                if (in_dmem_size[3:2] == 2'b00)        r_cnt_load    <= r_cnt_load + 32'd1;
                if (in_dmem_size[3:2] == 2'b01)        r_cnt_store   <= r_cnt_store + 32'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_cnt_drop != 16'hFFFF) r_cnt_drop <= r_cnt_drop + 16'd1;
            end
        end
    end

    assign out_valid   = (r_level != '0);
    assign out_data    = out_valid ? w_head[RW-1:32] : '0;
    assign out_seq     = out_valid ? w_head[31:0]    : '0;
    assign level       = r_level;
    assign cnt_inst    = r_cnt_inst;
    assign cnt_branch  = r_cnt_branch;
    assign cnt_taken   = r_cnt_taken;
    assign cnt_bp_miss = r_cnt_bp_miss;
    assign cnt_load    = r_cnt_load;
    assign cnt_store   = r_cnt_store;
    assign cnt_drop    = r_cnt_drop;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_ama_riscv_retire_tracer.sv
// Directed bench for the retire tracer: a per-cycle vector table plus
// hand-written sequences for overflow, full-with-pop, counters, clear and reset.
module tb_ama_riscv_retire_tracer;

    localparam int unsigned DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          trace_en;
    logic          cnt_clear;
    logic          in_valid;
    logic [31:0]   in_inst;
    logic [31:0]   in_pc;
    logic [31:0]   in_dmem_addr;
    logic          in_branch_inst;
    logic          in_branch_taken;
    logic          in_bp_hit;
    logic [3:0]    in_dmem_size;
    logic          out_valid;
    logic          out_ready;
    logic [102:0]  out_data;
    logic [31:0]   out_seq;
    logic [31:0]   cnt_inst;
    logic [31:0]   cnt_branch;
    logic [31:0]   cnt_taken;
    logic [31:0]   cnt_bp_miss;
    logic [31:0]   cnt_load;
    logic [31:0]   cnt_store;
    logic [15:0]   cnt_drop;
    logic          overflow;
    logic [2:0]    level;

    int n_vec;
    int n_err;

    ama_riscv_retire_tracer #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .trace_en        (trace_en),
        .cnt_clear       (cnt_clear),
        .in_valid        (in_valid),
        .in_inst         (in_inst),
        .in_pc           (in_pc),
        .in_dmem_addr    (in_dmem_addr),
        .in_branch_inst  (in_branch_inst),
        .in_branch_taken (in_branch_taken),
        .in_bp_hit       (in_bp_hit),
        .in_dmem_size    (in_dmem_size),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_seq         (out_seq),
        .cnt_inst        (cnt_inst),
        .cnt_branch      (cnt_branch),
        .cnt_taken       (cnt_taken),
        .cnt_bp_miss     (cnt_bp_miss),
        .cnt_load        (cnt_load),
        .cnt_store       (cnt_store),
        .cnt_drop        (cnt_drop),
        .overflow        (overflow),
        .level           (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        v;
        logic [31:0] pc;
        logic        rdy;
        logic        e_valid;
        logic [2:0]  e_level;
        logic [31:0] e_seq;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic en, input logic v, input logic [31:0] pc,
                           input logic rdy, input logic e_valid, input logic [2:0] e_level,
                           input logic [31:0] e_seq, input logic [31:0] e_pc,
                           input logic [31:0] e_cnt);
        vec_t t;
        t.en = en; t.v = v; t.pc = pc; t.rdy = rdy;
        t.e_valid = e_valid; t.e_level = e_level; t.e_seq = e_seq;
        t.e_pc = e_pc; t.e_cnt = e_cnt;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [3:0] sz,
                         input logic bi, input logic bt, input logic bh);
        in_valid        = v;
        in_pc           = pc;
        in_inst         = {pc[15:0], 16'h0013};
        in_dmem_addr    = pc + 32'h8000_0000;
        in_dmem_size    = sz;
        in_branch_inst  = bi;
        in_branch_taken = bt;
        in_bp_hit       = bh;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        trace_en  = 1'b0;
        cnt_clear = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 4'h8, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    logic [31:0] exp_seq_b [4];
    logic [31:0] exp_pc_b  [4];

    initial begin
        n_vec = 0;
        n_err = 0;
        rst       = 1'b0;
        trace_en  = 1'b0;
        cnt_clear = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 4'h8, 1'b0, 1'b0, 1'b0);
        #12;
        // Reset state
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_level", level, 3'd0);
        chk("rst_data", out_data, 103'd0);
        chk("rst_seq", out_seq, 32'd0);
        chk("rst_cnt_inst", cnt_inst, 32'd0);
        chk("rst_drop", cnt_drop, 16'd0);
        chk("rst_ovf", overflow, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Per-cycle table: en, v, pc, rdy | valid, level, seq, head pc, cnt_inst
        add_vec(1, 0, 32'h000, 1, 0, 0, 0, 32'h000, 0);
        add_vec(1, 1, 32'h100, 1, 1, 1, 0, 32'h100, 1);
        add_vec(1, 1, 32'h104, 1, 1, 1, 1, 32'h104, 2);
        add_vec(1, 1, 32'h108, 1, 1, 1, 2, 32'h108, 3);
        add_vec(1, 0, 32'h000, 1, 0, 0, 0, 32'h000, 3);
        add_vec(1, 1, 32'h200, 0, 1, 1, 3, 32'h200, 4);
        add_vec(1, 1, 32'h204, 0, 1, 2, 3, 32'h200, 5);
        add_vec(1, 0, 32'h000, 0, 1, 2, 3, 32'h200, 5);
        add_vec(1, 0, 32'h000, 1, 1, 1, 4, 32'h204, 5);
        add_vec(0, 1, 32'h300, 0, 1, 2, 4, 32'h204, 6);  // still ACTIVE this cycle
        add_vec(0, 1, 32'h304, 0, 1, 2, 4, 32'h204, 7);  // DRAIN: counted, not captured
        add_vec(0, 0, 32'h000, 1, 1, 1, 5, 32'h300, 7);
        add_vec(0, 0, 32'h000, 1, 0, 0, 0, 32'h000, 7);
        add_vec(0, 0, 32'h000, 0, 0, 0, 0, 32'h000, 7);  // DRAIN -> IDLE
        add_vec(1, 1, 32'h400, 0, 0, 0, 0, 32'h000, 8);  // IDLE: not captured
        add_vec(1, 1, 32'h404, 0, 1, 1, 8, 32'h404, 9);
        add_vec(1, 0, 32'h000, 1, 0, 0, 0, 32'h000, 9);

        for (int i = 0; i < tbl.size(); i++) begin
            trace_en  = tbl[i].en;
            out_ready = tbl[i].rdy;
            drive(tbl[i].v, tbl[i].pc, 4'h8, 1'b0, 1'b0, 1'b0);
            cyc();
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].e_level);
            chk($sformatf("tbl%0d_seq", i), out_seq, tbl[i].e_seq);
            chk($sformatf("tbl%0d_pc", i), out_data[70:39], tbl[i].e_pc);
            chk($sformatf("tbl%0d_cnt", i), cnt_inst, tbl[i].e_cnt);
        end

        // Overflow: DEPTH+2 retires with consumer stalled
        do_reset();
        trace_en = 1'b1;
        cyc();
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(1'b1, 32'h1000 + 32'(4 * i), 4'h8, 1'b0, 1'b0, 1'b0);
            cyc();
        end
        drive(1'b0, 32'h0, 4'h8, 1'b0, 1'b0, 1'b0);
        chk("ovf_level", level, 3'd4);
        chk("ovf_drop", cnt_drop, 16'd2);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_cnt_inst", cnt_inst, 32'd6);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("ovf_drain%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("ovf_drain%0d_seq", i), out_seq, 32'(i));
            chk($sformatf("ovf_drain%0d_pc", i), out_data[70:39], 32'h1000 + 32'(4 * i));
            out_ready = 1'b1;
            cyc();
            out_ready = 1'b0;
        end
        chk("ovf_empty", level, 3'd0);

        // Full FIFO with a same-cycle pop still accepts the push
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'h2000 + 32'(4 * i), 4'h8, 1'b0, 1'b0, 1'b0);
            cyc();
        end
        chk("full_level", level, 3'd4);
        drive(1'b1, 32'h3000, 4'h8, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        cyc();
        drive(1'b0, 32'h0, 4'h8, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        chk("fullpop_level", level, 3'd4);
        chk("fullpop_drop", cnt_drop, 16'd2);
        chk("fullpop_cnt", cnt_inst, 32'd11);
        exp_seq_b[0] = 32'd7;  exp_pc_b[0] = 32'h2004;
        exp_seq_b[1] = 32'd8;  exp_pc_b[1] = 32'h2008;
        exp_seq_b[2] = 32'd9;  exp_pc_b[2] = 32'h200C;
        exp_seq_b[3] = 32'd10; exp_pc_b[3] = 32'h3000;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fullpop_drain%0d_seq", i), out_seq, exp_seq_b[i]);
            chk($sformatf("fullpop_drain%0d_pc", i), out_data[70:39], exp_pc_b[i]);
            out_ready = 1'b1;
            cyc();
            out_ready = 1'b0;
        end
        chk("fullpop_empty", out_valid, 1'b0);

        // Mixed instruction mix for the perf counters (consumer stalled)
        do_reset();
        trace_en = 1'b1;
        cyc();
        drive(1'b1, 32'h4000, 4'h8, 1'b1, 1'b1, 1'b0); cyc();  // beq taken, miss
        drive(1'b1, 32'h4004, 4'h8, 1'b1, 1'b0, 1'b1); cyc();  // bne not taken, hit
        drive(1'b1, 32'h4008, 4'h2, 1'b0, 1'b0, 1'b0); cyc();  // lw
        drive(1'b1, 32'h400C, 4'h4, 1'b0, 1'b0, 1'b0); cyc();  // sb
        drive(1'b1, 32'h4010, 4'h8, 1'b0, 1'b0, 1'b0); cyc();  // add
        drive(1'b1, 32'h4014, 4'hF, 1'b0, 1'b1, 1'b0); cyc();  // non-branch, stray flags
        drive(1'b0, 32'h0, 4'h8, 1'b0, 1'b0, 1'b0);
        chk("mix_inst", cnt_inst, 32'd6);
        chk("mix_branch", cnt_branch, 32'd2);
        chk("mix_taken", cnt_taken, 32'd1);
        chk("mix_bp_miss", cnt_bp_miss, 32'd1);
        chk("mix_load", cnt_load, 32'd1);
        chk("mix_store", cnt_store, 32'd1);
        chk("mix_drop", cnt_drop, 16'd2);
        chk("mix_head_data", out_data,
            {32'h4000_0013, 32'h0000_4000, 32'h8000_4000, 4'h8, 3'b110});

        // Clear beats a same-cycle retire and a same-cycle drop
        cnt_clear = 1'b1;
        drive(1'b1, 32'h5000, 4'h2, 1'b1, 1'b1, 1'b0);
        cyc();
        cnt_clear = 1'b0;
        drive(1'b0, 32'h0, 4'h8, 1'b0, 1'b0, 1'b0);
        chk("clr_inst", cnt_inst, 32'd0);
        chk("clr_branch", cnt_branch, 32'd0);
        chk("clr_taken", cnt_taken, 32'd0);
        chk("clr_bp_miss", cnt_bp_miss, 32'd0);
        chk("clr_load", cnt_load, 32'd0);
        chk("clr_store", cnt_store, 32'd0);
        chk("clr_drop", cnt_drop, 16'd0);
        chk("clr_ovf", overflow, 1'b0);
        chk("clr_level", level, 3'd4);
        chk("clr_head_pc", out_data[70:39], 32'h4000);
        drive(1'b1, 32'h5004, 4'h4, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 4'h8, 1'b0, 1'b0, 1'b0);
        chk("postclr_drop", cnt_drop, 16'd1);
        chk("postclr_ovf", overflow, 1'b1);
        chk("postclr_inst", cnt_inst, 32'd1);
        chk("postclr_store", cnt_store, 32'd1);

        // Asynchronous reset mid-operation discards the queued records
        #2;
        rst = 1'b0;
        #1;
        chk("arst_level", level, 3'd0);
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_data", out_data, 103'd0);
        chk("arst_seq", out_seq, 32'd0);
        chk("arst_inst", cnt_inst, 32'd0);
        chk("arst_drop", cnt_drop, 16'd0);
        chk("arst_ovf", overflow, 1'b0);
        cyc();
        rst = 1'b1;
        cyc();
        drive(1'b1, 32'h0777, 4'h8, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 4'h8, 1'b0, 1'b0, 1'b0);
        chk("arst_first_valid", out_valid, 1'b1);
        chk("arst_first_seq", out_seq, 32'd0);
        chk("arst_first_pc", out_data[70:39], 32'h0777);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
